// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
// Shares one SRAM-like port between the fetch channel and the MEM-stage data
// channel. Data has strict priority when the port is free; a grant stays locked
// until its address handshake completes. A small order FIFO records the source
// of every accepted request so in-order returns can be steered back.
//
// state  | meaning
// IDLE   | port free, grant chosen combinationally (data first)
// LOCK_I | fetch request presented but not yet accepted, fetch owns the port
// LOCK_D | data request presented but not yet accepted, data owns the port
module sram_req_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int AW = $clog2(OUTSTANDING);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(OUTSTANDING);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

  state_t                 state, state_nxt;
  grant_t                 grant;
  logic [OUTSTANDING-1:0] src_id;   // 1 = data channel issued this entry
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, push, pop, head_d;

  assign full   = (count == FULL_CNT);
  assign push   = mem_req & mem_addr_ok;
  assign pop    = mem_data_ok & (count != '0);
  assign head_d = src_id[rd_ptr];

  // Grant state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Grant selection, request mux and lock next-state
  always_comb begin
    grant     = GNT_NONE;
    state_nxt = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;

    case (state)
      LOCK_I:  grant = GNT_I;
      LOCK_D:  grant = GNT_D;
      default: begin
        if (data_req)      grant = GNT_D;
        else if (inst_req) grant = GNT_I;
      end
    endcase

    case (grant)
      GNT_I: begin
        mem_req  = inst_req & ~full & resetn;
        mem_size = 2'd2;
        mem_addr = inst_addr;
      end
      GNT_D: begin
        mem_req   = data_req & ~full & resetn;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      default: ;
    endcase

    // A full FIFO freezes the lock so the owner keeps the port once space frees
    if (!full) begin
      if (mem_req && !mem_addr_ok)
        state_nxt = (grant == GNT_D) ? LOCK_D : LOCK_I;
      else if (mem_req)
        state_nxt = IDLE;
    end
  end

  // Order FIFO: source of each accepted request, popped on every in-order return
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_id <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        src_id[wr_ptr] <= (grant == GNT_D);
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign inst_addr_ok = push & (grant == GNT_I);
  assign data_addr_ok = push & (grant == GNT_D);
  assign inst_data_ok = pop & ~head_d;
  assign data_data_ok = pop & head_d;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: directed vector table, hand sequences for
// ordering/full/reset, then random traffic against a queue-based model.
module tb_sram_req_arbiter;

  localparam int OUT = 4;
  localparam logic [31:0] IA = 32'hbfc0_0000;
  localparam logic [31:0] DA = 32'h1000_0001;
  localparam logic [31:0] DW = 32'h0000_00aa;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_req_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (0 none, 1 inst, 2 data) and the
  // issue-order list of outstanding requests (1 = data).
  int owner = 0;
  bit order_q[$];

  typedef struct {
    logic        ireq, dreq, dwr, aok, dok;
    logic [31:0] rdata;
    logic        e_req, e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    logic        e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare all outputs with the model for the current inputs, then advance it.
  task automatic settle();
    int  g;
    bit  full, req, hd;
    #1;
    g    = (owner != 0) ? owner : (data_req ? 2 : (inst_req ? 1 : 0));
    full = (order_q.size() == OUT);
    req  = ((g == 1) ? inst_req : (g == 2) ? data_req : 1'b0) && !full;
    hd   = (order_q.size() != 0) ? order_q[0] : 1'b0;
    if (owner == 1) chk("m_inst_held", inst_req, 1);
    if (owner == 2) chk("m_data_held", data_req, 1);
    chk("m_mem_req",   mem_req, req);
    chk("m_mem_wr",    mem_wr,    (g == 2) ? data_wr : 1'b0);
    chk("m_mem_size",  mem_size,  (g == 2) ? data_size : (g == 1) ? 2'd2 : 2'd0);
    chk("m_mem_wstrb", mem_wstrb, (g == 2) ? data_wstrb : 4'd0);
    chk("m_mem_addr",  mem_addr,  (g == 2) ? data_addr : (g == 1) ? inst_addr : 32'd0);
    chk("m_mem_wdata", mem_wdata, (g == 2) ? data_wdata : 32'd0);
    chk("m_inst_addr_ok", inst_addr_ok, req && mem_addr_ok && g == 1);
    chk("m_data_addr_ok", data_addr_ok, req && mem_addr_ok && g == 2);
    chk("m_inst_data_ok", inst_data_ok, mem_data_ok && order_q.size() != 0 && !hd);
    chk("m_data_data_ok", data_data_ok, mem_data_ok && order_q.size() != 0 && hd);
    if (mem_data_ok && order_q.size() != 0) begin
      chk("m_rdata", hd ? data_rdata : inst_rdata, mem_rdata);
      void'(order_q.pop_front());
    end
    if (req && mem_addr_ok) order_q.push_back(g == 2);
    if (!full) begin
      if (req && !mem_addr_ok) owner = g;
      else if (req)            owner = 0;
    end
  endtask

  task automatic clear_inputs();
    inst_req = 0; data_req = 0; data_wr = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  bit i_pend, d_pend;

  initial begin
    // ireq dreq dwr aok dok rdata | req wr size wstrb addr wdata | iaok daok idok ddok
    tbl[0]  = '{0,0,0,0,0,32'h0,          0,0,2'd0,4'd0,32'h0,32'h0, 0,0,0,0};
    tbl[1]  = '{1,0,0,0,0,32'h0,          1,0,2'd2,4'd0,IA,32'h0,    0,0,0,0};
    tbl[2]  = '{1,0,0,1,0,32'h0,          1,0,2'd2,4'd0,IA,32'h0,    1,0,0,0};
    tbl[3]  = '{0,0,0,0,0,32'h0,          0,0,2'd0,4'd0,32'h0,32'h0, 0,0,0,0};
    tbl[4]  = '{0,0,0,0,1,32'h3c1d_0001,  0,0,2'd0,4'd0,32'h0,32'h0, 0,0,1,0};
    tbl[5]  = '{1,1,1,1,0,32'h0,          1,1,2'd0,4'd2,DA,DW,       0,1,0,0};
    tbl[6]  = '{1,0,0,1,0,32'h0,          1,0,2'd2,4'd0,IA,32'h0,    1,0,0,0};
    tbl[7]  = '{0,0,0,0,1,32'h1111_1111,  0,0,2'd0,4'd0,32'h0,32'h0, 0,0,0,1};
    tbl[8]  = '{0,0,0,0,1,32'h2222_2222,  0,0,2'd0,4'd0,32'h0,32'h0, 0,0,1,0};
    tbl[9]  = '{0,1,0,0,0,32'h0,          1,0,2'd0,4'd2,DA,DW,       0,0,0,0};
    tbl[10] = '{1,1,0,0,0,32'h0,          1,0,2'd0,4'd2,DA,DW,       0,0,0,0};
    tbl[11] = '{1,1,0,0,0,32'h0,          1,0,2'd0,4'd2,DA,DW,       0,0,0,0};
    tbl[12] = '{1,1,0,1,0,32'h0,          1,0,2'd0,4'd2,DA,DW,       0,1,0,0};
    tbl[13] = '{1,0,0,1,0,32'h0,          1,0,2'd2,4'd0,IA,32'h0,    1,0,0,0};
    tbl[14] = '{0,0,0,0,1,32'h3333_3333,  0,0,2'd0,4'd0,32'h0,32'h0, 0,0,0,1};
    tbl[15] = '{0,0,0,0,1,32'h4444_4444,  0,0,2'd0,4'd0,32'h0,32'h0, 0,0,1,0};
    tbl[16] = '{0,0,0,0,1,32'h5555_5555,  0,0,2'd0,4'd0,32'h0,32'h0, 0,0,0,0};

    inst_addr = IA; data_addr = DA; data_wdata = DW;
    data_size = 2'd0; data_wstrb = 4'b0010;
    clear_inputs();

    // Reset state: handshakes forced low even with all requests active
    resetn = 0;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_iaok", inst_addr_ok, 0);
    chk("rst_daok", data_addr_ok, 0);
    chk("rst_idok", inst_data_ok, 0);
    chk("rst_ddok", data_data_ok, 0);
    clear_inputs();
    @(negedge clk);
    resetn = 1;
    @(negedge clk);

    // Directed vectors: inst-only, collision, lock, drop
    for (int i = 0; i < 17; i++) begin
      inst_req = tbl[i].ireq; data_req = tbl[i].dreq; data_wr = tbl[i].dwr;
      mem_addr_ok = tbl[i].aok; mem_data_ok = tbl[i].dok; mem_rdata = tbl[i].rdata;
      settle();
      chk($sformatf("v%0d_mem_req", i),   mem_req,   tbl[i].e_req);
      chk($sformatf("v%0d_mem_wr", i),    mem_wr,    tbl[i].e_wr);
      chk($sformatf("v%0d_mem_size", i),  mem_size,  tbl[i].e_size);
      chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb, tbl[i].e_wstrb);
      chk($sformatf("v%0d_mem_addr", i),  mem_addr,  tbl[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_iaok", i), inst_addr_ok, tbl[i].e_iaok);
      chk($sformatf("v%0d_daok", i), data_addr_ok, tbl[i].e_daok);
      chk($sformatf("v%0d_idok", i), inst_data_ok, tbl[i].e_idok);
      chk($sformatf("v%0d_ddok", i), data_data_ok, tbl[i].e_ddok);
      if (tbl[i].e_idok) chk($sformatf("v%0d_irdata", i), inst_rdata, tbl[i].rdata);
      if (tbl[i].e_ddok) chk($sformatf("v%0d_drdata", i), data_rdata, tbl[i].rdata);
      tick();
    end
    clear_inputs();

    // Ordering: I,D,I,D issued back to back, returns steered in the same order
    for (int k = 0; k < 4; k++) begin
      inst_req = (k % 2 == 0); data_req = (k % 2 == 1); mem_addr_ok = 1;
      settle();
      chk("ord_addr_ok", (k % 2 == 0) ? inst_addr_ok : data_addr_ok, 1);
      tick();
    end
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1; mem_rdata = $urandom;
      settle();
      chk("ord_idok", inst_data_ok, k % 2 == 0);
      chk("ord_ddok", data_data_ok, k % 2 == 1);
      tick();
    end
    clear_inputs();
    settle();
    chk("ord_count", dut.count, 0);
    tick();

    // Full: four accepted, fifth blocked, re-asserts the cycle after a return
    for (int k = 0; k < 4; k++) begin
      inst_req = 1; inst_addr = IA + 32'(4 * k); mem_addr_ok = 1;
      settle();
      chk("full_fill_iaok", inst_addr_ok, 1);
      tick();
    end
    inst_addr = 32'hbfc0_0100;
    settle();
    chk("full_mem_req", mem_req, 0);
    chk("full_iaok", inst_addr_ok, 0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'hcafe_0001;
    settle();
    chk("full_pop_mem_req", mem_req, 0);
    chk("full_pop_idok", inst_data_ok, 1);
    tick();
    mem_data_ok = 0;
    settle();
    chk("full_reassert", mem_req, 1);
    chk("full_reassert_iaok", inst_addr_ok, 1);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    for (int k = 0; k < 4; k++) begin
      mem_data_ok = 1;
      settle();
      chk("full_drain_idok", inst_data_ok, 1);
      tick();
    end
    clear_inputs();
    inst_addr = IA;

    // Reset with two in flight discards tracking immediately
    for (int k = 0; k < 2; k++) begin
      inst_req = 1; mem_addr_ok = 1;
      settle();
      tick();
    end
    mem_data_ok = 1;
    #2;
    resetn = 0;
    #1;
    chk("rst2_count", dut.count, 0);
    chk("rst2_mem_req", mem_req, 0);
    chk("rst2_iaok", inst_addr_ok, 0);
    chk("rst2_daok", data_addr_ok, 0);
    chk("rst2_idok", inst_data_ok, 0);
    chk("rst2_ddok", data_data_ok, 0);
    order_q.delete();
    owner = 0;
    tick();
    clear_inputs();
    resetn = 1;
    tick();
    mem_data_ok = 1; mem_rdata = 32'hdead_beef;
    settle();
    chk("drop_idok", inst_data_ok, 0);
    chk("drop_ddok", data_data_ok, 0);
    tick();
    clear_inputs();

    // Random traffic; masters hold request and fields until accepted
    i_pend = 0; d_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_pend) begin
        inst_req  = ($urandom_range(0, 2) == 0);
        inst_addr = $urandom;
        i_pend    = inst_req;
      end
      if (!d_pend) begin
        data_req   = ($urandom_range(0, 2) == 0);
        data_wr    = $urandom_range(0, 1);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
        d_pend     = data_req;
      end
      mem_addr_ok = ($urandom_range(0, 1) == 1);
      mem_data_ok = ($urandom_range(0, 4) < 2);
      mem_rdata   = $urandom;
      settle();
      if (inst_addr_ok) i_pend = 0;
      if (data_addr_ok) d_pend = 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
